// File: rtl/multdiv_pkg.sv
// Shared types and constants for the mul/div scheduler.
// Optional status reporting is enabled by defining MULTDIV_STATUS_EN.
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      PEND = 2'd2
   } md_state_e;

   localparam int DEF_REG_W    = 5;
   localparam int RSTATUS_REG  = 30;
   localparam int MUL_EXC_CODE = 4;
   localparam int DIV_EXC_CODE = 5;

   function automatic logic [31:0] exc_code(input logic is_div);
      return is_div ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
   endfunction

endpackage

// File: rtl/multdiv_scheduler_if.sv
// Pipeline <-> mul/div scheduler signal bundle; the pipeline side is master.
// Start pulses and writeback are combinational; no flow control beyond the stalls.
interface multdiv_scheduler_if #(
   parameter int REG_W = 5
);
   logic             x_is_mul;
   logic             x_is_div;
   logic [REG_W-1:0] x_rd;
   logic [REG_W-1:0] d_rs;
   logic [REG_W-1:0] d_rt;
   logic [REG_W-1:0] d_rd;
   logic             d_writes_rd;
   logic [31:0]      md_result;
   logic             md_ready;
   logic             md_exception;
   logic             mw_we;
   logic [REG_W-1:0] mw_rd;
   logic [31:0]      mw_data;
   logic             start_mult;
   logic             start_div;
   logic             stall_fd;
   logic             stall_x;
   logic             freeze_all;
   logic             wb_we;
   logic [REG_W-1:0] wb_rd;
   logic [31:0]      wb_data;
   logic             md_busy;

   modport master (
      output x_is_mul, x_is_div, x_rd, d_rs, d_rt, d_rd, d_writes_rd,
             md_result, md_ready, md_exception, mw_we, mw_rd, mw_data,
      input  start_mult, start_div, stall_fd, stall_x, freeze_all,
             wb_we, wb_rd, wb_data, md_busy
   );

   modport slave (
      input  x_is_mul, x_is_div, x_rd, d_rs, d_rt, d_rd, d_writes_rd,
             md_result, md_ready, md_exception, mw_we, mw_rd, mw_data,
      output start_mult, start_div, stall_fd, stall_x, freeze_all,
             wb_we, wb_rd, wb_data, md_busy
   );
endinterface

// File: rtl/md_hazard_cmp.sv
// Combinational RAW/WAW compare of D fields against the in-flight mul/div rd, plus X structural stall.
// Zero latency; status_chk adds the status register to the compare set.
module md_hazard_cmp
   import multdiv_pkg::*;
#(
   parameter int REG_W = DEF_REG_W
) (
   input  logic             active,
   input  logic [REG_W-1:0] held_rd,
   input  logic             status_chk,
   input  logic [REG_W-1:0] d_rs,
   input  logic [REG_W-1:0] d_rt,
   input  logic [REG_W-1:0] d_rd,
   input  logic             d_writes_rd,
   input  logic             x_is_mdu,
   output logic             stall_fd,
   output logic             stall_x
);
   logic             rd_live;
   logic [REG_W-1:0] status_reg;
   logic             hit_rs;
   logic             hit_rt;
   logic             hit_rd;

   assign rd_live    = (held_rd != '0);
   assign status_reg = REG_W'(RSTATUS_REG);

   assign hit_rs = (rd_live && d_rs == held_rd) || (status_chk && d_rs == status_reg);
   assign hit_rt = (rd_live && d_rt == held_rd) || (status_chk && d_rt == status_reg);
   assign hit_rd = d_writes_rd &&
                   ((rd_live && d_rd == held_rd) || (status_chk && d_rd == status_reg));

   assign stall_x  = active && x_is_mdu;
   assign stall_fd = stall_x || (active && (hit_rs || hit_rt || hit_rd));
endmodule

// File: rtl/multdiv_scheduler.sv
// Issues mul/div starts, tracks the in-flight rd, and shares the regfile write port with MW.
// Starts are same-cycle; a completed result waits at most MAX_HOLD MW writes, then freezes the pipe.
// Optional macro MULTDIV_STATUS_EN: exceptions write a status code to register 30.
module multdiv_scheduler
   import multdiv_pkg::*;
#(
   parameter int REG_W      = DEF_REG_W,
   parameter int MAX_HOLD   = 4,
   parameter int HOLD_CNT_W = 3
) (
   input logic                clock,
   input logic                reset,
   multdiv_scheduler_if.slave bus
);
   md_state_e             state_q, state_d;
   logic [REG_W-1:0]      held_rd_q, held_rd_d;
   logic [31:0]           result_q, result_d;
   logic [HOLD_CNT_W-1:0] hold_q, hold_d;

   logic             x_mdu;
   logic             md_busy;
   logic             pw_write;
   logic             keep_exc;
   logic             status_chk;
   logic [REG_W-1:0] pw_rd;
   logic [31:0]      pw_data;
   logic             start_mult;
   logic             start_div;
   logic             freeze_all;

   assign x_mdu   = bus.x_is_mul | bus.x_is_div;
   assign md_busy = (state_q != IDLE);

`ifdef MULTDIV_STATUS_EN
   logic exc_q, exc_d;
   logic is_div_q, is_div_d;

   always_comb begin
      exc_d    = exc_q;
      is_div_d = is_div_q;
      if (state_q == IDLE && x_mdu) begin
         is_div_d = ~bus.x_is_mul;
      end
      if (state_q == BUSY && bus.md_ready) begin
         exc_d = bus.md_exception;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         exc_q    <= 1'b0;
         is_div_q <= 1'b0;
      end else begin
         exc_q    <= exc_d;
         is_div_q <= is_div_d;
      end
   end

   assign keep_exc   = bus.md_exception;
   assign status_chk = 1'b1;
   assign pw_rd      = exc_q ? REG_W'(RSTATUS_REG) : held_rd_q;
   assign pw_data    = exc_q ? exc_code(is_div_q) : result_q;
`else
   assign keep_exc   = 1'b0;
   assign status_chk = 1'b0;
   assign pw_rd      = held_rd_q;
   assign pw_data    = result_q;
`endif

   always_comb begin
      state_d    = state_q;
      held_rd_d  = held_rd_q;
      result_d   = result_q;
      hold_d     = hold_q;
      start_mult = 1'b0;
      start_div  = 1'b0;
      freeze_all = 1'b0;
      pw_write   = 1'b0;
      case (state_q)
         IDLE: begin
            // Starts are gated by reset so nothing launches while the block is being cleared.
            if (!reset) begin
               start_mult = bus.x_is_mul;
               start_div  = bus.x_is_div & ~bus.x_is_mul;
            end
            if (x_mdu) begin
               held_rd_d = bus.x_rd;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (bus.md_ready) begin
               result_d = bus.md_result;
               hold_d   = '0;
               state_d  = (held_rd_q != '0 || keep_exc) ? PEND : IDLE;
            end
         end
         PEND: begin
            if (!bus.mw_we) begin
               pw_write = 1'b1;
               state_d  = IDLE;
            end else if (hold_q < HOLD_CNT_W'(MAX_HOLD)) begin
               hold_d = hold_q + 1'b1;
            end else begin
               // MW's latch is frozen this cycle, so its write is replayed next cycle.
               freeze_all = 1'b1;
               pw_write   = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         held_rd_q <= '0;
         result_q  <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         held_rd_q <= held_rd_d;
         result_q  <= result_d;
         hold_q    <= hold_d;
      end
   end

   md_hazard_cmp #(.REG_W(REG_W)) u_hazard (
      .active      (md_busy),
      .held_rd     (held_rd_q),
      .status_chk  (status_chk),
      .d_rs        (bus.d_rs),
      .d_rt        (bus.d_rt),
      .d_rd        (bus.d_rd),
      .d_writes_rd (bus.d_writes_rd),
      .x_is_mdu    (x_mdu),
      .stall_fd    (bus.stall_fd),
      .stall_x     (bus.stall_x)
   );

   assign bus.start_mult = start_mult;
   assign bus.start_div  = start_div;
   assign bus.freeze_all = freeze_all;
   assign bus.md_busy    = md_busy;
   assign bus.wb_we      = pw_write | bus.mw_we;
   assign bus.wb_rd      = pw_write ? pw_rd : bus.mw_rd;
   assign bus.wb_data    = pw_write ? pw_data : bus.mw_data;
endmodule

// File: tb/tb_multdiv_scheduler.sv
// Bench for multdiv_scheduler: directed scenarios with literal expectations plus a randomized
// run compared every cycle against a transaction-level model (in-flight op / pending result).
module tb_multdiv_scheduler;
   localparam int REG_W    = 5;
   localparam int MAX_HOLD = 4;
`ifdef MULTDIV_STATUS_EN
   localparam bit STATUS = 1'b1;
`else
   localparam bit STATUS = 1'b0;
`endif

   logic clock;
   logic reset;
   int   checks;
   int   failures;
   bit   chk_en;

   multdiv_scheduler_if #(.REG_W(REG_W)) bus ();

   multdiv_scheduler #(.REG_W(REG_W), .MAX_HOLD(MAX_HOLD), .HOLD_CNT_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: an op issued and awaiting its result, and a result awaiting the write port.
   bit        m_inflight;
   bit        m_pending;
   int        m_rd;
   bit        m_div;
   bit        m_exc;
   int        m_result;
   int        m_waits;

   function automatic bit hit(input int r);
      return (m_rd != 0 && r == m_rd) || (STATUS && r == 30);
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_inflight = 0;
         m_pending  = 0;
         m_rd       = 0;
         m_waits    = 0;
      end else if (!m_inflight && !m_pending) begin
         if (bus.x_is_mul || bus.x_is_div) begin
            m_inflight = 1;
            m_rd       = int'(bus.x_rd);
            m_div      = !bus.x_is_mul;
         end
      end else if (m_inflight) begin
         if (bus.md_ready) begin
            m_inflight = 0;
            m_exc      = STATUS && bus.md_exception;
            m_result   = int'(bus.md_result);
            m_waits    = 0;
            m_pending  = (m_rd != 0) || m_exc;
         end
      end else begin
         if (!bus.mw_we || m_waits == MAX_HOLD) m_pending = 0;
         else m_waits++;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         bit          active, pw_now, xmd, raw;
         logic [31:0] t_rd, t_data;
         active = m_inflight || m_pending;
         pw_now = m_pending && (!bus.mw_we || m_waits == MAX_HOLD);
         xmd    = bus.x_is_mul || bus.x_is_div;
         raw    = hit(int'(bus.d_rs)) || hit(int'(bus.d_rt)) ||
                  (bus.d_writes_rd && hit(int'(bus.d_rd)));
         t_rd   = m_exc ? 32'd30 : 32'(m_rd);
         t_data = m_exc ? (m_div ? 32'd5 : 32'd4) : 32'(m_result);
         chk("m_start_mult", 32'(bus.start_mult), 32'(!reset && !active && bus.x_is_mul));
         chk("m_start_div", 32'(bus.start_div),
             32'(!reset && !active && bus.x_is_div && !bus.x_is_mul));
         chk("m_stall_x", 32'(bus.stall_x), 32'(active && xmd));
         chk("m_stall_fd", 32'(bus.stall_fd), 32'(active && (xmd || raw)));
         chk("m_freeze", 32'(bus.freeze_all), 32'(m_pending && bus.mw_we && m_waits == MAX_HOLD));
         chk("m_md_busy", 32'(bus.md_busy), 32'(active));
         chk("m_wb_we", 32'(bus.wb_we), 32'(pw_now || bus.mw_we));
         chk("m_wb_rd", 32'(bus.wb_rd), pw_now ? t_rd : 32'(bus.mw_rd));
         chk("m_wb_data", bus.wb_data, pw_now ? t_data : bus.mw_data);
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clock);
   endtask

   initial begin
      checks = 0; failures = 0; chk_en = 0;
      m_inflight = 0; m_pending = 0; m_rd = 0; m_div = 0; m_exc = 0; m_result = 0; m_waits = 0;
      reset = 1'b1;
      bus.x_is_mul = 0; bus.x_is_div = 0; bus.x_rd = '0;
      bus.d_rs = '0; bus.d_rt = '0; bus.d_rd = '0; bus.d_writes_rd = 0;
      bus.md_result = '0; bus.md_ready = 0; bus.md_exception = 0;
      bus.mw_we = 0; bus.mw_rd = '0; bus.mw_data = '0;
      cyc();
      chk_en = 1;
      cyc();
      reset = 1'b0;
      at_neg();
      chk("rst_busy", 32'(bus.md_busy), 0);
      chk("rst_start", 32'(bus.start_mult | bus.start_div), 0);
      chk("rst_stall", 32'(bus.stall_fd | bus.stall_x), 0);
      chk("rst_freeze", 32'(bus.freeze_all), 0);
      chk("rst_wb_we", 32'(bus.wb_we), 0);
      cyc();
      bus.mw_we = 1; bus.mw_rd = 5'd4; bus.mw_data = 32'h55;
      at_neg();
      chk("pass_wb_rd", 32'(bus.wb_rd), 4);
      chk("pass_wb_data", bus.wb_data, 32'h55);
      cyc();
      bus.mw_we = 0;

      // mul rd=7, D dependency, queued div behind it
      bus.x_is_mul = 1; bus.x_rd = 5'd7;
      at_neg();
      chk("mul_start", 32'(bus.start_mult), 1);
      cyc();
      bus.x_is_mul = 0;
      for (int i = 1; i <= 31; i++) begin
         bus.d_rs   = (i == 10) ? 5'd8 : 5'd7;
         bus.x_is_div = (i >= 20);
         bus.x_rd   = 5'd9;
         at_neg();
         if (i == 10) chk("rs8_nostall", 32'(bus.stall_fd), 0);
         else chk("rs7_stall", 32'(bus.stall_fd), 1);
         if (i >= 20) begin
            chk("div_stall_x", 32'(bus.stall_x), 1);
            chk("div_no_start", 32'(bus.start_div), 0);
         end
         cyc();
      end
      bus.md_ready = 1; bus.md_result = 32'h2A;
      at_neg();
      chk("busy_no_wb", 32'(bus.wb_we), 0);
      cyc();
      bus.md_ready = 0; bus.md_result = '0;
      at_neg();
      chk("pw_we", 32'(bus.wb_we), 1);
      chk("pw_rd", 32'(bus.wb_rd), 7);
      chk("pw_data", bus.wb_data, 32'h2A);
      chk("pw_div_held", 32'(bus.start_div), 0);
      cyc();
      at_neg();
      chk("idle_busy", 32'(bus.md_busy), 0);
      chk("div_start", 32'(bus.start_div), 1);
      cyc();
      bus.x_is_div = 0; bus.d_rs = '0;
      at_neg();
      chk("div_once", 32'(bus.start_div), 0);
      chk("div_busy", 32'(bus.md_busy), 1);

      // div rd=9 completes while MW writes every cycle
      cyc();
      bus.md_ready = 1; bus.md_result = 32'h99;
      bus.mw_we = 1; bus.mw_rd = 5'd3; bus.mw_data = 32'h11;
      cyc();
      bus.md_ready = 0;
      for (int i = 0; i < 10; i++) begin
         at_neg();
         if (i < 4) begin
            chk("hold_freeze", 32'(bus.freeze_all), 0);
            chk("hold_wb_rd", 32'(bus.wb_rd), 3);
            chk("hold_wb_data", bus.wb_data, 32'h11);
         end else if (i == 4) begin
            chk("frz_freeze", 32'(bus.freeze_all), 1);
            chk("frz_wb_rd", 32'(bus.wb_rd), 9);
            chk("frz_wb_data", bus.wb_data, 32'h99);
         end else if (i == 5) begin
            chk("replay_freeze", 32'(bus.freeze_all), 0);
            chk("replay_wb_rd", 32'(bus.wb_rd), 3);
            chk("replay_busy", 32'(bus.md_busy), 0);
         end
         cyc();
      end
      bus.mw_we = 0;

      // rd=0 result is dropped
      bus.x_is_mul = 1; bus.x_rd = 5'd0;
      cyc();
      bus.x_is_mul = 0;
      cyc();
      bus.md_ready = 1; bus.md_result = 32'h77;
      cyc();
      bus.md_ready = 0;
      at_neg();
      chk("rd0_no_wb", 32'(bus.wb_we), 0);
      chk("rd0_idle", 32'(bus.md_busy), 0);
      cyc();

`ifdef MULTDIV_STATUS_EN
      bus.x_is_div = 1; bus.x_rd = 5'd12;
      cyc();
      bus.x_is_div = 0;
      cyc();
      bus.md_ready = 1; bus.md_exception = 1; bus.md_result = 32'h1234;
      cyc();
      bus.md_ready = 0; bus.md_exception = 0;
      at_neg();
      chk("exc_wb_rd", 32'(bus.wb_rd), 30);
      chk("exc_wb_data", bus.wb_data, 5);
      cyc();
`endif

      // reset while BUSY, then a late md_ready
      bus.x_is_mul = 1; bus.x_rd = 5'd5;
      cyc();
      bus.x_is_mul = 1; bus.x_rd = 5'd6;
      cyc();
      reset = 1;
      at_neg();
      chk("rst_no_start", 32'(bus.start_mult), 0);
      cyc();
      reset = 0; bus.x_is_mul = 0;
      bus.md_ready = 1; bus.md_result = 32'h5; bus.d_rs = 5'd5;
      at_neg();
      chk("late_busy", 32'(bus.md_busy), 0);
      chk("late_stall", 32'(bus.stall_fd), 0);
      cyc();
      bus.md_ready = 0;
      at_neg();
      chk("late_no_wb", 32'(bus.wb_we), 0);
      chk("late_idle", 32'(bus.md_busy), 0);
      cyc();

      for (int n = 0; n < 3000; n++) begin
         reset            = ($urandom_range(0, 199) == 0);
         bus.x_is_mul     = ($urandom_range(0, 5) == 0);
         bus.x_is_div     = ($urandom_range(0, 5) == 0);
         bus.x_rd         = REG_W'($urandom_range(0, 9));
         bus.d_rs         = ($urandom_range(0, 15) == 0) ? 5'd30 : REG_W'($urandom_range(0, 9));
         bus.d_rt         = REG_W'($urandom_range(0, 9));
         bus.d_rd         = REG_W'($urandom_range(0, 9));
         bus.d_writes_rd  = $urandom_range(0, 1) == 1;
         bus.md_ready     = ($urandom_range(0, 7) == 0);
         bus.md_exception = ($urandom_range(0, 3) == 0);
         bus.md_result    = $urandom;
         bus.mw_we        = ($urandom_range(0, 3) != 0);
         bus.mw_rd        = REG_W'($urandom);
         bus.mw_data      = $urandom;
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
